uart_rx_module: RTL

8N1 UART receiver for the FPGA serial link; consumes the serial stream produced by the board's UART transmit stage (115200 baud at 25 MHz). Synchronises the asynchronous rx line, validates the start bit, samples each bit at mid-period, and presents one received byte per frame with a single-cycle strobe. Detects framing errors and overrun of an unread byte.

---
 rtl/uart_rx_module.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, framing/overrun flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_module #(
    parameter int CLK_DIV  = 217,
    parameter int HALF_DIV = CLK_DIV / 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] BIT_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        pending;
    logic        bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic s2;
    logic s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (clk_cnt == 16'd2) s2 <= rx_s;
            if (clk_cnt == 16'd1) s1 <= rx_s;
        end
    end

    assign bit_val = (s2 & s1) | (s2 & rx_s) | (s1 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (data_ack) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        clk_cnt <= HALF_M1;
                        state   <= START;
                    end
                end
                START: begin
                    if (clk_cnt == 16'd0) begin
                        if (!bit_val) begin
                            clk_cnt <= BIT_M1;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == 16'd0) begin
                        shift   <= {bit_val, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        clk_cnt <= BIT_M1;
                        if (bit_cnt == 4'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (clk_cnt == 16'd0) begin
                        if (bit_val) begin
                            // a same-cycle ack consumes the old byte, so no overrun
                            data_out <= shift;
                            valid    <= 1'b1;
                            pending  <= 1'b1;
                            overrun  <= data_ack ? 1'b0 : (overrun | pending);
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end
                end
                BRK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
